// File: rtl/ref_mem_ctrl_param.sv
// Reference-memory controller: preloads bank groups line by line, then issues two-pass
// search reads per column with a one-time reuse of STALL_ROW in each pass.
module ref_mem_ctrl_param #(
    parameter int unsigned NBANK     = 32,
    parameter int unsigned GRP       = 4,
    parameter int unsigned LINES     = 96,
    parameter int unsigned AW        = 7,
    parameter int unsigned ROWS      = 20,
    parameter int unsigned BASE0     = 0,
    parameter int unsigned BASE1     = 24,
    parameter int unsigned STALL_ROW = 3,
    parameter int unsigned NCOL      = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr_valid_in,
    input  logic                  rd_hold,
    output logic [NBANK-1:0]      bank_sel,
    output logic                  wr_en,
    output logic [NBANK*AW-1:0]   write_address_all,
    output logic                  rd_en,
    output logic [NBANK*AW-1:0]   rd_address_all,
    output logic [3:0]            rdR_sel,
    output logic                  pass,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NGRP = NBANK / GRP;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW   = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [1:0] {StIdle, StPreload, StSearch} state_t;

    state_t          state_q;
    logic [AW-1:0]   line_q;
    logic [GW-1:0]   group_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            pass_q;
    logic            reuse_q;
    logic            fin_q;

    logic [NBANK-1:0] bank_sel_nxt;
    logic [AW-1:0]    rd_addr_nxt;

    always_comb begin
        bank_sel_nxt = '0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            bank_sel_nxt[b] = ((b / GRP) == 32'(group_q));
        end
        // Address arithmetic wraps modulo 2^AW by construction.
        rd_addr_nxt = (pass_q ? AW'(BASE1) : AW'(BASE0)) + AW'(row_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= StIdle;
            line_q            <= '0;
            group_q           <= '0;
            row_q             <= '0;
            col_q             <= '0;
            pass_q            <= 1'b0;
            reuse_q           <= 1'b0;
            fin_q             <= 1'b0;
            bank_sel          <= '0;
            wr_en             <= 1'b0;
            write_address_all <= '0;
            rd_en             <= 1'b0;
            rd_address_all    <= '0;
            rdR_sel           <= '0;
            pass              <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                    rd_en <= 1'b0;
                    if (start) begin
                        state_q <= StPreload;
                        busy    <= 1'b1;
                        line_q  <= '0;
                        group_q <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        pass_q  <= 1'b0;
                        reuse_q <= 1'b0;
                        fin_q   <= 1'b0;
                        rdR_sel <= '0;
                        pass    <= 1'b0;
                    end
                end
                StPreload: begin
                    if (wr_valid_in) begin
                        wr_en             <= 1'b1;
                        bank_sel          <= bank_sel_nxt;
                        write_address_all <= {NBANK{line_q}};
                        if (line_q == AW'(LINES - 1)) begin
                            line_q <= '0;
                            if (group_q == GW'(NGRP - 1)) begin
                                state_q <= StSearch;
                            end else begin
                                group_q <= group_q + GW'(1);
                            end
                        end else begin
                            line_q <= line_q + AW'(1);
                        end
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                StSearch: begin
                    wr_en    <= 1'b0;
                    bank_sel <= '0;
                    if (fin_q) begin
                        rd_en   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        fin_q   <= 1'b0;
                        state_q <= StIdle;
                    end else if (rd_hold) begin
                        rd_en <= 1'b0;
                    end else begin
                        rd_en          <= 1'b1;
                        rd_address_all <= {NBANK{rd_addr_nxt}};
                        rdR_sel        <= 4'(col_q);
                        pass           <= pass_q;
                        // Stall row is issued once more before the row counter moves on.
                        if (row_q == RW'(STALL_ROW) && !reuse_q) begin
                            reuse_q <= 1'b1;
                        end else if (row_q == RW'(ROWS - 1)) begin
                            row_q   <= '0;
                            reuse_q <= 1'b0;
                            if (!pass_q) begin
                                pass_q <= 1'b1;
                            end else begin
                                pass_q <= 1'b0;
                                if (col_q == CW'(NCOL - 1)) begin
                                    fin_q <= 1'b1;
                                end else begin
                                    col_q <= col_q + CW'(1);
                                end
                            end
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ref_mem_ctrl_param.sv
// Directed bench for ref_mem_ctrl_param at default parameters.
module tb_ref_mem_ctrl_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         wr_valid_in;
    logic         rd_hold;
    logic [31:0]  bank_sel;
    logic         wr_en;
    logic [223:0] write_address_all;
    logic         rd_en;
    logic [223:0] rd_address_all;
    logic [3:0]   rdR_sel;
    logic         pass;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    ref_mem_ctrl_param dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .wr_valid_in       (wr_valid_in),
        .rd_hold           (rd_hold),
        .bank_sel          (bank_sel),
        .wr_en             (wr_en),
        .write_address_all (write_address_all),
        .rd_en             (rd_en),
        .rd_address_all    (rd_address_all),
        .rdR_sel           (rdR_sel),
        .pass              (pass),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [223:0] rep(input logic [6:0] a);
        return {32{a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {bank_sel, wr_en, write_address_all, rd_en, rd_address_all,
                    rdR_sel, pass, busy, done}, '0);
    endtask

    // Write k goes to group k/96 (mask 0xF shifted by 4 per group) at line k%96.
    task automatic do_preload(input bit toggle);
        logic [31:0]  eb;
        logic [223:0] ea;
        int           k;
        int           cycles;
        k      = 0;
        eb     = '0;
        ea     = '0;
        cycles = toggle ? 1535 : 768;
        for (int c = 0; c < cycles; c++) begin
            wr_valid_in = !toggle || (c % 2 == 0);
            tick();
            if (wr_valid_in) begin
                eb = 32'hF << (4 * (k / 96));
                ea = rep(7'(k % 96));
                k++;
                check("wr_en", wr_en, 1'b1);
            end else begin
                check("wr_gap_en", wr_en, 1'b0);
            end
            check("bank_sel", bank_sel, eb);
            check("wr_addr", write_address_all, ea);
        end
        wr_valid_in = 1'b0;
    endtask

    // Read j: column j/42; first 21 reads of a column are pass 0 (base 0), next 21 pass 1
    // (base 24); within a pass rows go 0,1,2,3,3,4..19.
    task automatic do_search(input int hold_at, input int stop_at);
        int col, r, q, row, a;
        bit p;
        for (int j = 0; j < 294; j++) begin
            if (j == stop_at) return;
            if (j == hold_at) begin
                rd_hold = 1'b1;
                repeat (5) begin
                    tick();
                    check("hold_rd_en", rd_en, 1'b0);
                    check("hold_addr", rd_address_all, rep(7'd3));
                end
                rd_hold = 1'b0;
            end
            tick();
            col = j / 42;
            r   = j % 42;
            p   = (r >= 21);
            q   = r % 21;
            row = (q <= 3) ? q : q - 1;
            a   = (p ? 24 : 0) + row;
            check("rd_en", rd_en, 1'b1);
            check("rd_addr", rd_address_all, rep(7'(a)));
            check("rdR_sel", rdR_sel, 4'(col));
            check("pass", pass, p);
            if (j == 0) begin
                check("srch_wr_en", wr_en, 1'b0);
                check("srch_bank_sel", bank_sel, 32'h0);
            end
        end
        tick();
        check("done_set", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_rd_en", rd_en, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        wr_valid_in = 1'b0;
        rd_hold     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outs");
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        // Run A: continuous preload, free-running search.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_wr_en", wr_en, 1'b0);
        do_preload(1'b0);
        do_search(-1, -1);
        tick();
        check("done_pulse", done, 1'b0);
        check("idle_busy_a", busy, 1'b0);

        // Run B: gapped preload, hold during the stall-row repeat.
        start = 1'b1;
        tick();
        start = 1'b0;
        do_preload(1'b1);
        do_search(4, -1);
        tick();

        // Run C: start held high, reset mid-search at read 100.
        start = 1'b1;
        tick();
        do_preload(1'b0);
        do_search(-1, 100);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Run D: start still high; full run, then restart accepted from the done cycle.
        tick();
        check("restart_busy", busy, 1'b1);
        do_preload(1'b0);
        do_search(-1, -1);
        tick();
        check("rerun_busy", busy, 1'b1);
        check("rerun_done", done, 1'b0);
        check("rerun_wr_en", wr_en, 1'b0);
        start       = 1'b0;
        wr_valid_in = 1'b1;
        tick();
        check("rerun_first_wr", wr_en, 1'b1);
        check("rerun_bank_sel", bank_sel, 32'h0000000F);
        check("rerun_wr_addr", write_address_all, rep(7'd0));
        wr_valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ref_mem_ctrl_param.md
REF_MEM_CTRL_PARAM -- requirements
Module: ref_mem_ctrl_param

Interface
REQ-001 SHALL have parameter NBANK, default 32, the number of reference-memory banks.
REQ-002 SHALL have parameter GRP, default 4, the banks written together per preload group; NBANK must be divisible by GRP.
REQ-003 SHALL have parameter LINES, default 96, the lines written per group.
REQ-004 SHALL have parameter AW, default 7, the per-bank address width.
REQ-005 SHALL have parameter ROWS, default 20, the rows read per search pass.
REQ-006 SHALL have parameters BASE0 and BASE1, defaults 0 and 24, the read-address offsets of pass 0 and pass 1.
REQ-007 SHALL have parameter STALL_ROW, default 3, the pass-relative row that is issued twice for reference reuse.
REQ-008 SHALL have parameter NCOL, default 7, the search columns per run.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-011 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-012 SHALL have port wr_valid_in, input, 1 bit: preload pixel data is available this cycle.
REQ-013 SHALL have port rd_hold, input, 1 bit: PE not ready, freezes the search.
REQ-014 SHALL have port bank_sel, output, NBANK bits: one-hot group mask.
REQ-015 SHALL have port wr_en, output, 1 bit: write strobe.
REQ-016 SHALL have port write_address_all, output, NBANK*AW bits: write address replicated to all banks.
REQ-017 SHALL have port rd_en, output, 1 bit: read strobe.
REQ-018 SHALL have port rd_address_all, output, NBANK*AW bits: read address replicated to all banks.
REQ-019 SHALL have port rdR_sel, output, 4 bits: current column index.
REQ-020 SHALL have port pass, output, 1 bit: 0 for sub-block 1/2 and 1 for sub-block 3/4.
REQ-021 SHALL have ports busy and done, outputs, 1 bit each.

Function
REQ-022 SHALL implement states IDLE, PRELOAD, SEARCH; all outputs registered.
REQ-023 IDLE: start=1 at an edge SHALL move to PRELOAD, set busy=1, and clear the line, group, row, pass and column counters.
REQ-024 PRELOAD: at each edge with wr_valid_in=1, SHALL register wr_en=1, bank_sel bits [g*GRP +: GRP]=1 (others 0), and write_address_all={NBANK{line}}, then advance line.
- line wraps LINES-1 -> 0 and increments group g.
REQ-025 PRELOAD with wr_valid_in=0 SHALL register wr_en=0 and hold the counters, bank_sel and write_address_all.
REQ-026 The edge registering the last write (g=NBANK/GRP-1, line=LINES-1) SHALL also move to SEARCH.
- Next cycle: wr_en=0, bank_sel=0.
REQ-027 SEARCH, rd_hold=0, SHALL register rd_en=1 and rd_address_all={NBANK{(BASEp+row) mod 2^AW}}, with BASEp selected by pass.
REQ-028 Within each pass, row STALL_ROW SHALL be issued on two consecutive enabled cycles (reuse flag set on first, cleared on pass change), so each pass is ROWS+1 reads.
REQ-029 SEARCH, rd_hold=1, SHALL register rd_en=0 and hold all counters, the reuse flag and the address.
REQ-030 After the final read of pass 0, SHALL switch to pass 1, row 0.
REQ-031 After the final read of pass 1, SHALL set pass 0 and increment the column.
REQ-032 rdR_sel SHALL equal the column zero-extended to 4 bits.
REQ-033 After the final read of column NCOL-1, the next edge SHALL give rd_en=0, done=1 for exactly one cycle, busy=0, and return to IDLE.
REQ-034 start during PRELOAD or SEARCH SHALL be ignored.
REQ-035 start in the done cycle SHALL be accepted at the following edge.
REQ-036 Row and column counters SHALL be wide enough for ROWS and NCOL; addresses SHALL wrap modulo 2^AW without error.

Reset
REQ-037 rst=1 SHALL immediately force IDLE and all outputs to 0, including mid-PRELOAD and mid-SEARCH, and clear all counters and the reuse flag.
REQ-038 The first start after reset release SHALL behave as from a fresh power-up.

Verification
REQ-039 Defaults, start pulse, wr_valid_in=1 constantly -> 768 wr_en cycles; bank_sel 0x0000000F for 96 cycles, then 0x000000F0 and so on up to 0xF0000000; addresses 0..95 per group.
REQ-040 wr_valid_in toggling 1,0 each cycle -> still exactly 768 writes in 1535 cycles; outputs held during gaps.
REQ-041 Search, rd_hold=0 -> per column, addresses 0,1,2,3,3,4..19 then 24,25,26,27,27,28..43 (42 reads); 294 reads total; rdR_sel 0..6; done one cycle after read 294.
REQ-042 rd_hold=1 for 5 cycles at pass-0 row 3 repeat -> rd_en=0 for 5 cycles; the repeated address 3 still appears exactly twice.
REQ-043 rst asserted at read 100, then start again -> all outputs 0 immediately; the new run starts with a full 768-write preload.
REQ-044 start held high through the run and into the done cycle -> a second run begins one edge after done; no start is accepted mid-run.
